// File: rtl/iob2axi_burst_gen.sv
// Splits a (dir, addr, beats) transfer into AXI bursts that respect MAX_BURST and 2^BOUNDARY_W crossings.
// run -> first cmd_valid 2 cycles, handshake -> next cmd_valid 2 cycles; cmd_valid held low while MAX_OUT bursts are open.
module iob2axi_burst_gen #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int LENGTH_W   = 16,
  parameter int MAX_BURST  = 256,
  parameter int BOUNDARY_W = 12,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  direction,
  input  logic [AXI_ADDR_W-1:0] addr,
  input  logic [LENGTH_W-1:0]   length,
  output logic                  ready,
  output logic                  error,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_dir,
  output logic [AXI_ADDR_W-1:0] cmd_addr,
  output logic [AXI_LEN_W-1:0]  cmd_len,
  output logic                  cmd_last,
  input  logic                  done_valid,
  input  logic [1:0]            done_resp
);

  localparam int BYTES = AXI_DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int OW    = $clog2(MAX_OUT + 1);
  localparam int BW0   = (LENGTH_W > BOUNDARY_W + 1) ? LENGTH_W : BOUNDARY_W + 1;
  localparam int BW    = (BW0 > AXI_LEN_W + 1) ? BW0 : AXI_LEN_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [AXI_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LENGTH_W-1:0]   remaining_q, remaining_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  error_q, error_d;
  logic [AXI_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [AXI_LEN_W-1:0]  cmd_len_q, cmd_len_d;
  logic                  cmd_last_q, cmd_last_d;
  logic [BW-1:0]         beats_q, beats_d;

  logic [BOUNDARY_W:0]   span;
  logic [BOUNDARY_W:0]   to_bnd;
  logic [BW-1:0]         rem_ext;
  logic [BW-1:0]         beats_c;
  logic                  bad_req;
  logic                  hs;
  logic                  dec;

  // A boundary-aligned address needs the extra bit to express a full 2^BOUNDARY_W span.
  assign span    = {1'b1, {BOUNDARY_W{1'b0}}} - {1'b0, cur_addr_q[BOUNDARY_W-1:0]};
  assign to_bnd  = span >> OFFS;
  assign rem_ext = BW'(remaining_q);

  always_comb begin
    beats_c = rem_ext;
    if (BW'(to_bnd) < beats_c)    beats_c = BW'(to_bnd);
    if (BW'(MAX_BURST) < beats_c) beats_c = BW'(MAX_BURST);
  end

  assign bad_req   = (length == '0) || ((addr & AXI_ADDR_W'(BYTES - 1)) != '0);
  assign cmd_valid = (state_q == S_ISSUE) && (out_q < OW'(MAX_OUT));
  assign hs        = cmd_valid && cmd_ready;
  assign dec       = done_valid && (out_q != '0);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    error_d     = error_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_last_d  = cmd_last_q;
    beats_d     = beats_q;
    out_d       = out_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          dir_d       = direction;
          cur_addr_d  = addr;
          remaining_d = length;
          error_d     = bad_req;
          if (!bad_req) state_d = S_CALC;
        end
      end
      S_CALC: begin
        cmd_addr_d = cur_addr_q;
        cmd_len_d  = AXI_LEN_W'(beats_c - BW'(1));
        cmd_last_d = (beats_c == rem_ext);
        beats_d    = beats_c;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (hs) begin
          cur_addr_d  = cur_addr_q + (AXI_ADDR_W'(beats_q) << OFFS);
          remaining_d = remaining_q - LENGTH_W'(beats_q);
          state_d     = cmd_last_q ? S_DRAIN : S_CALC;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completion with nothing outstanding is a protocol fault from the engine.
    if (done_valid && ((out_q == '0) || (done_resp != 2'b00))) error_d = 1'b1;

    case ({hs, dec})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      out_q       <= '0;
      error_q     <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_last_q  <= 1'b0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      error_q     <= error_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      cmd_last_q  <= cmd_last_d;
      beats_q     <= beats_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign error    = error_q;
  assign cmd_dir  = dir_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_len  = cmd_len_q;
  assign cmd_last = cmd_last_q;

endmodule

// File: tb/tb_iob2axi_burst_gen.sv
// Directed bench for iob2axi_burst_gen: table of transfers with expected bursts, plus
// hand-written sequences for in-flight throttling, simultaneous issue/complete and mid-transfer reset.
module tb_iob2axi_burst_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        direction;
  logic [31:0] addr;
  logic [15:0] length;
  logic        ready;
  logic        error;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_last;
  logic        done_valid;
  logic [1:0]  done_resp;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  iob2axi_burst_gen #(
    .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8), .LENGTH_W(16),
    .MAX_BURST(256), .BOUNDARY_W(12), .MAX_OUT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .direction(direction), .addr(addr),
    .length(length), .ready(ready), .error(error), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_last(cmd_last), .done_valid(done_valid), .done_resp(done_resp)
  );

  typedef struct {
    logic [31:0]       addr;
    logic [15:0]       len;
    logic              dir;
    int                bad_idx;
    int                n;
    logic [0:2][31:0]  ea;
    logic [0:2][7:0]   el;
    logic              err;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [15:0] l, input logic d,
                              input int bad, input int n,
                              input logic [31:0] a0, input logic [7:0] l0,
                              input logic [31:0] a1, input logic [7:0] l1,
                              input logic [31:0] a2, input logic [7:0] l2, input logic e);
    vec_t v;
    v.addr = a; v.len = l; v.dir = d; v.bad_idx = bad; v.n = n;
    v.ea = {a0, a1, a2};
    v.el = {l0, l1, l2};
    v.err = e;
    return v;
  endfunction

  // Runs one transfer with cmd_ready=1 and a completion 3 cycles after every handshake.
  task automatic do_xfer(input int idx, input vec_t v);
    logic [31:0] ga[$];
    logic [7:0]  gl[$];
    logic        glast[$];
    int          gk[$];
    int          pend[$];
    int          ndone;
    int          k;
    logic        fin;

    @(negedge clk);
    run = 1'b1; addr = v.addr; length = v.len; direction = v.dir;
    cmd_ready = 1'b1; done_valid = 1'b0; done_resp = 2'b00;
    ndone = 0; k = 0; fin = 1'b0;
    while (!fin && k < 2000) begin
      @(negedge clk);
      k++;
      run = 1'b0; addr = 32'hDEAD_0000; length = 16'd7; direction = ~v.dir;
      if (k == 1) chk($sformatf("v%0d err_after_run", idx), error, (v.n == 0));
      done_valid = 1'b0; done_resp = 2'b00;
      foreach (pend[i]) pend[i] = pend[i] - 1;
      if (pend.size() > 0 && pend[0] == 0) begin
        void'(pend.pop_front());
        done_valid = 1'b1;
        done_resp  = (ndone == v.bad_idx) ? 2'b10 : 2'b00;
        ndone++;
      end
      if (cmd_valid && cmd_ready) begin
        ga.push_back(cmd_addr); gl.push_back(cmd_len); glast.push_back(cmd_last); gk.push_back(k);
        chk($sformatf("v%0d cmd_dir", idx), cmd_dir, v.dir);
        pend.push_back(3);
      end
      fin = ready;
    end
    done_valid = 1'b0;
    chk($sformatf("v%0d finished", idx), fin, 1'b1);
    chk($sformatf("v%0d n_cmds", idx), ga.size(), v.n);
    for (int i = 0; i < v.n && i < ga.size(); i++) begin
      chk($sformatf("v%0d cmd%0d addr", idx, i), ga[i], v.ea[i]);
      chk($sformatf("v%0d cmd%0d len", idx, i), gl[i], v.el[i]);
      chk($sformatf("v%0d cmd%0d last", idx, i), glast[i], (i == v.n - 1));
      if (i == 0) chk($sformatf("v%0d first_latency", idx), gk[0], 2);
      else        chk($sformatf("v%0d gap%0d", idx, i), gk[i] - gk[i-1], 2);
    end
    chk($sformatf("v%0d error_end", idx), error, v.err);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d error_idle_hold", idx), error, v.err);
  endtask

  initial begin
    int hs;
    int k;

    rst_n = 1'b0; run = 1'b0; direction = 1'b0; addr = '0; length = '0;
    cmd_ready = 1'b0; done_valid = 1'b0; done_resp = 2'b00;

    vt[0] = mk(32'h1000, 16, 0, -1, 1, 32'h1000, 15, 0, 0, 0, 0, 0);
    vt[1] = mk(32'h1FF0, 16, 1, -1, 2, 32'h1FF0, 3, 32'h2000, 11, 0, 0, 0);
    vt[2] = mk(32'h0000, 600, 0, -1, 3, 32'h0000, 255, 32'h0400, 255, 32'h0800, 87, 0);
    vt[3] = mk(32'h1FF0, 16, 1, 0, 2, 32'h1FF0, 3, 32'h2000, 11, 0, 0, 1);
    vt[4] = mk(32'h1000, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[5] = mk(32'h1002, 4, 0, -1, 0, 0, 0, 0, 0, 0, 0, 1);
    vt[6] = mk(32'hFFFF_FFF8, 4, 1, -1, 2, 32'hFFFF_FFF8, 1, 32'h0000_0000, 1, 0, 0, 0);
    vt[7] = mk(32'h0FFC, 1, 0, -1, 1, 32'h0FFC, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst ready", ready, 1'b1);
    chk("rst error", error, 1'b0);
    chk("rst cmd_valid", cmd_valid, 1'b0);
    chk("rst cmd_addr", cmd_addr, 32'h0);
    chk("rst cmd_len", cmd_len, 8'h0);
    chk("rst cmd_last", cmd_last, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_xfer(i, vt[i]);

    // Completions withheld: third burst must wait for a free in-flight slot.
    @(negedge clk);
    run = 1'b1; addr = 32'h0; length = 16'd600; direction = 1'b0; cmd_ready = 1'b1;
    hs = 0; k = 0;
    while (hs < 2 && k < 50) begin
      @(negedge clk);
      k++;
      run = 1'b0;
      if (cmd_valid && cmd_ready) hs++;
    end
    chk("hold two_handshakes", hs, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run = 1'b1; addr = 32'h1234; length = 16'd3;
      chk($sformatf("hold cmd_valid_low%0d", i), cmd_valid, 1'b0);
    end
    chk("hold cmd_addr", cmd_addr, 32'h800);
    chk("hold busy", ready, 1'b0);
    run = 1'b0; done_valid = 1'b1; done_resp = 2'b00;
    @(negedge clk);
    chk("hold valid_after_done", cmd_valid, 1'b1);
    chk("hold third_len", cmd_len, 8'd87);
    chk("hold third_last", cmd_last, 1'b1);
    done_valid = 1'b1;
    @(negedge clk);
    chk("same_cycle drain_busy", ready, 1'b0);
    done_valid = 1'b1;
    @(negedge clk);
    done_valid = 1'b0;
    chk("same_cycle still_draining", ready, 1'b0);
    @(negedge clk);
    chk("same_cycle idle", ready, 1'b1);
    chk("same_cycle no_error", error, 1'b0);

    // Asynchronous reset while a command is pending.
    @(negedge clk);
    run = 1'b1; addr = 32'h40; length = 16'd8; cmd_ready = 1'b0;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("rst_mid valid_before", cmd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid cmd_valid", cmd_valid, 1'b0);
    chk("rst_mid ready", ready, 1'b1);
    chk("rst_mid cmd_addr", cmd_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid stays_idle", ready, 1'b1);
    chk("rst_mid no_cmd", cmd_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
